mac_input_feeder: RTL and testbench
===================================

// Module: mac_input_feeder
// PURPOSE
//  Upstream stage of the saturating MAC. Buffers (a,b) operand pairs arriving on a
//  valid/ready stream in a small FIFO. Under a start/frame_len command it issues
//  exactly frame_len pairs to the MAC as a, b, valid_in pulses, then pulses done.
//  The MAC has no backpressure, so this block owns all stalling and pacing.
// PARAMETERS
//  WIDTH   10  operand width (signed two's complement); must match the MAC a/b width
//  DEPTH    8  FIFO entries; power of 2, >=2; AW = $clog2(DEPTH)
//  LENW    16  width of frame_len and of the issued-pair counter
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        synchronous, active-high
//  in_valid   in   1        producer has a pair on in_a/in_b
//  in_a       in   WIDTH    operand a, signed
//  in_b       in   WIDTH    operand b, signed
//  in_ready   out  1        FIFO can accept; write occurs when in_valid && in_ready
//  start      in   1        begin frame; sampled only in IDLE
//  frame_len  in   LENW     pairs to issue; captured on accepted start
//  a          out  WIDTH    to MAC a, registered
//  b          out  WIDTH    to MAC b, registered
//  valid_in   out  1        to MAC valid_in, one-cycle pulse per issued pair
//  busy       out  1        high in RUN and DONE
//  done       out  1        one-cycle pulse after last pair issued
//  level      out  AW+1     FIFO occupancy 0..DEPTH
// BEHAVIOUR
//  Reset: FIFO emptied (level=0), state=IDLE; a=0, b=0, valid_in=0, done=0, busy=0,
//   in_ready=1 on the first cycle after reset. Reset mid-frame discards buffered pairs
//   and the remaining count. Nothing is issued in the reset cycle.
//  FIFO: circular buffer, rd/wr pointers AW+1 bits (MSB wrap bit), full when
//   pointers differ only in MSB. in_ready = !full, decoded from registers only, with
//   no combinational path from in_valid. When full, no write that cycle even if a
//   read also occurs. Writes are accepted in every state, IDLE included (prefill allowed).
//   Simultaneous read+write when not full: level unchanged, both happen.
//  FSM:
//   IDLE: start=1 -> capture frame_len, clear issued count, go RUN. If frame_len==0,
//         go DONE instead.
//   RUN : each cycle FIFO non-empty -> pop head, register a/b, valid_in=1 next cycle,
//         issued++. FIFO empty -> valid_in=0, a/b hold (stall). When the pop makes
//         issued==frame_len -> go DONE.
//   DONE: done=1 for exactly one cycle, then IDLE. start is ignored outside IDLE.
//  Latency: a pair written at edge t can be popped at edge t+1, so the earliest
//   valid_in is high in the cycle after edge t+1. Throughput is 1 pair/cycle.
//  a/b keep the last issued values while valid_in=0. No data is altered; values pass
//   through bit-exact.
//  done rises in the cycle after the last valid_in cycle. The MAC result still follows
//   its own pipeline latency.
// CONFIGURATION
//  MAC_FEEDER_STATS_EN defined: adds output port stall_cycles [15:0]. It counts cycles
//   in RUN with an empty FIFO, saturates at 16'hFFFF, clears on accepted start and
//   on reset.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Prefill 3 pairs (1,2),(3,4),(5,6) in IDLE, start frame_len=3 -> valid_in high 3
//    consecutive cycles with a/b=1/2,3/4,5/6; done pulses the next cycle; level=0.
//  2 Push 8 pairs with no start (DEPTH=8) -> in_ready=0 and level=8; a 9th in_valid is
//    not accepted. Start frame_len=8 -> 8 pairs issued in order; in_ready returns 1.
//  3 start frame_len=4 with empty FIFO, then feed 1 pair every 3 cycles -> 4 valid_in
//    pulses spaced 3 cycles; busy stays high throughout; [STATS] stall_cycles > 0.
//  4 start frame_len=0 -> busy 1 cycle, done pulses, no valid_in; buffered pairs
//    are kept.
//  5 Signed extremes (-512,-512),(511,-512) issued -> a/b bit-exact at MAC ports.
//  6 Assert reset mid-frame with 5 buffered -> next cycle level=0, valid_in=0, IDLE;
//    a new start then needs fresh data.

Source files
------------

// File: rtl/mac_input_feeder.sv
// ---------------------------------------------------------------------------
// mac_input_feeder
//
// Upstream stage of the saturating MAC. Operand pairs (a,b) arrive on a
// valid/ready stream and are buffered in a small circular FIFO. A start
// command with frame_len issues exactly frame_len pairs to the MAC as
// registered a/b values with a one-cycle valid_in pulse per pair. done then
// pulses once. The MAC cannot stall, so all pacing and stalling happens here.
//
// Optional feature:
//   MAC_FEEDER_STATS_EN  when defined, adds output stall_cycles[15:0]. It
//                        counts RUN cycles spent waiting on an empty FIFO.
//                        The counter saturates at 16'hFFFF and clears on an
//                        accepted start or on reset.
//
// Parameters:
//   WIDTH  operand width (signed two's complement), must match the MAC
//   DEPTH  FIFO entries, power of two, >= 2
//   LENW   width of frame_len and of the issued-pair counter
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-high reset
//   in_valid      in   producer has a pair on in_a/in_b
//   in_a, in_b    in   operand pair (signed)
//   in_ready      out  FIFO can accept a pair (driven from registers only)
//   start         in   begin a frame; sampled only in IDLE
//   frame_len     in   number of pairs to issue; captured on accepted start
//   a, b          out  registered operands to the MAC
//   valid_in      out  one-cycle pulse per issued pair
//   busy          out  high in RUN and DONE
//   done          out  one-cycle pulse in the cycle after the last valid_in
//   level         out  FIFO occupancy, 0..DEPTH
//   stall_cycles  out  (MAC_FEEDER_STATS_EN only) empty-FIFO cycles in RUN
// ---------------------------------------------------------------------------
module mac_input_feeder #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8,
   parameter int LENW  = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             in_ready,
   input  logic             start,
   input  logic [LENW-1:0]  frame_len,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             valid_in,
   output logic             busy,
   output logic             done,
   output logic [AW:0]      level
`ifdef MAC_FEEDER_STATS_EN
   ,
   output logic [15:0]      stall_cycles
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   // FIFO storage and pointers
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             full;
   logic             empty;
   logic             wr_en;
   logic             pop;

   // frame bookkeeping
   logic [LENW-1:0]  len_q;
   logic [LENW-1:0]  issued;
   logic             start_acc;
   logic             remaining;

   // The pointers carry one extra wrap bit: equal pointers mean empty, and
   // pointers that differ only in the wrap bit mean full.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign level = wr_ptr - rd_ptr;

   // in_ready depends only on registered pointers, never on in_valid, and a
   // full FIFO refuses a write even when a pop frees a slot the same cycle.
   assign in_ready = !full;
   assign wr_en    = in_valid && !full;

   assign start_acc = (state == IDLE) && start;
   assign remaining = (issued != len_q);

   // A pair is popped only while the frame still owes pairs, so the cycle in
   // which issued reaches len_q never pops, and it is the valid_in cycle of
   // the last pair.
   assign pop = (state == RUN) && !empty && remaining;

   // FIFO write side
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_a[wr_ptr[AW-1:0]] <= in_a;
         mem_b[wr_ptr[AW-1:0]] <= in_b;
      end
   end

   // FIFO pointer update; reset discards any buffered pairs.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Frame length capture and issued-pair counter
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q  <= '0;
         issued <= '0;
      end else if (start_acc) begin
         len_q  <= frame_len;
         issued <= '0;
      end else if (pop) begin
         issued <= issued + LENW'(1);
      end
   end

   // Registered MAC operands: a/b load only on a pop and otherwise hold the
   // last issued pair, so a stall leaves them untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         a        <= '0;
         b        <= '0;
         valid_in <= 1'b0;
      end else begin
         valid_in <= pop;
         if (pop) begin
            a <= mem_a[rd_ptr[AW-1:0]];
            b <= mem_b[rd_ptr[AW-1:0]];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic. RUN leaves once the count is complete, one cycle
   // after the final pop, so that done lands right after the last valid_in.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (frame_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (!remaining) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN: begin
            busy = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

`ifdef MAC_FEEDER_STATS_EN
   // Stall counter: RUN cycles where pairs are still owed but none is buffered.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (start_acc) begin
         stall_cycles <= '0;
      end else if ((state == RUN) && empty && remaining &&
                   (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mac_input_feeder.sv
// ---------------------------------------------------------------------------
// tb_mac_input_feeder
//
// Directed testbench for mac_input_feeder (WIDTH=10, DEPTH=8, LENW=16).
// Pairs pushed into the FIFO are also queued locally in push order; every
// valid_in pulse must present the pair at the front of that queue.
// ---------------------------------------------------------------------------
module tb_mac_input_feeder;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [9:0]  in_a;
   logic [9:0]  in_b;
   logic        in_ready;
   logic        start;
   logic [15:0] frame_len;
   logic [9:0]  a;
   logic [9:0]  b;
   logic        valid_in;
   logic        busy;
   logic        done;
   logic [3:0]  level;
`ifdef MAC_FEEDER_STATS_EN
   logic [15:0] stall_cycles;
`endif

   int total;
   int bad;
   logic [19:0] exp_q [$];

   mac_input_feeder #(
      .WIDTH(10),
      .DEPTH(8),
      .LENW (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_a     (in_a),
      .in_b     (in_b),
      .in_ready (in_ready),
      .start    (start),
      .frame_len(frame_len),
      .a        (a),
      .b        (b),
      .valid_in (valid_in),
      .busy     (busy),
      .done     (done),
      .level    (level)
`ifdef MAC_FEEDER_STATS_EN
      ,
      .stall_cycles(stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge, then settle so outputs reflect the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Push one pair through the stream interface and record it as expected.
   task automatic applyStimulus(input logic [9:0] va, input logic [9:0] vb);
      in_valid = 1'b1;
      in_a     = va;
      in_b     = vb;
      exp_q.push_back({va, vb});
      tick();
      in_valid = 1'b0;
   endtask

   task automatic startFrame(input logic [15:0] len);
      start     = 1'b1;
      frame_len = len;
      tick();
      start = 1'b0;
   endtask

   // Watch a running frame: every valid_in pulse is checked against the
   // queue, then pair count, done count and done placement are checked.
   task automatic collectFrame(input string tag, input int n,
                               input bit consec, input int timeout);
      int got_n;
      int cyc;
      int first_v;
      int last_v;
      int done_n;
      int done_cyc;
      logic [19:0] e;
      got_n = 0; cyc = 0; first_v = -1; last_v = -1; done_n = 0; done_cyc = -1;
      while (cyc < timeout && done_n == 0) begin
         tick();
         cyc++;
         if (valid_in) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hFFFFF;
            checkOutput({tag, "_pair"}, {12'b0, a, b}, {12'b0, e});
            got_n++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (done) begin
            done_n++;
            done_cyc = cyc;
         end
      end
      checkOutput({tag, "_count"}, got_n, n);
      checkOutput({tag, "_done"}, done_n, 1);
      if (n > 0) begin
         checkOutput({tag, "_done_pos"}, done_cyc, last_v + 1);
      end
      if (consec && n > 0) begin
         checkOutput({tag, "_consec"}, last_v - first_v + 1, n);
      end
   endtask

   initial begin
      int last_v;
      int space_bad;
      int fed;
      int nval;
      int done_seen;
      bit busy_drop;
      bit stray_valid;

      total = 0;
      bad = 0;
      reset = 1'b1;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      start = 1'b0;
      frame_len = '0;
      tick();
      tick();
      reset = 1'b0;

      // reset state
      checkOutput("rst_level", level, 0);
      checkOutput("rst_ready", in_ready, 1);
      checkOutput("rst_valid", valid_in, 0);
      checkOutput("rst_ab", {a, b}, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);

      // 1: prefill three pairs in IDLE, then a frame of three
      applyStimulus(10'd1, 10'd2);
      applyStimulus(10'd3, 10'd4);
      applyStimulus(10'd5, 10'd6);
      checkOutput("t1_level_pre", level, 3);
      checkOutput("t1_busy_idle", busy, 0);
      startFrame(16'd3);
      collectFrame("t1", 3, 1'b1, 20);
      checkOutput("t1_level_post", level, 0);
      tick();
      checkOutput("t1_busy_after", busy, 0);
      checkOutput("t1_done_after", done, 0);

      // 2: fill the FIFO, try one more, then drain all eight in order
      for (int i = 0; i < 8; i++) begin
         applyStimulus(10'(i * 10 + 7), 10'(1000 - i));
      end
      checkOutput("t2_ready_full", in_ready, 0);
      checkOutput("t2_level_full", level, 8);
      in_valid = 1'b1;
      in_a = 10'd99;
      in_b = 10'd99;
      tick();
      in_valid = 1'b0;
      checkOutput("t2_level_9th", level, 8);
      startFrame(16'd8);
      collectFrame("t2", 8, 1'b1, 30);
      checkOutput("t2_ready_after", in_ready, 1);
      checkOutput("t2_level_after", level, 0);
      tick();

      // 3: frame of four from an empty FIFO, one pair every three cycles
      startFrame(16'd4);
      fed = 0; nval = 0; last_v = -1; space_bad = 0; done_seen = 0;
      busy_drop = 1'b0;
      for (int k = 0; k < 40 && done_seen == 0; k++) begin
         if ((k % 3) == 0 && fed < 4) begin
            in_valid = 1'b1;
            in_a = 10'(100 + fed);
            in_b = 10'(200 + fed);
            exp_q.push_back({10'(100 + fed), 10'(200 + fed)});
            fed++;
         end else begin
            in_valid = 1'b0;
         end
         tick();
         if (!busy) busy_drop = 1'b1;
         if (valid_in) begin
            checkOutput("t3_pair", {12'b0, a, b}, {12'b0, exp_q.pop_front()});
            if (last_v >= 0 && (k - last_v) != 3) space_bad++;
            last_v = k;
            nval++;
         end
         if (done) done_seen = 1;
      end
      in_valid = 1'b0;
      checkOutput("t3_count", nval, 4);
      checkOutput("t3_spacing", space_bad, 0);
      checkOutput("t3_busy_held", {31'b0, busy_drop}, 0);
      checkOutput("t3_done", done_seen, 1);
`ifdef MAC_FEEDER_STATS_EN
      checkOutput("t3_stalls_nonzero", {31'b0, stall_cycles != 16'd0}, 1);
`endif
      tick();

      // 4: zero-length frame keeps buffered pairs
      applyStimulus(10'd11, 10'd22);
      applyStimulus(10'd33, 10'd44);
      startFrame(16'd0);
      checkOutput("t4_busy", busy, 1);
      checkOutput("t4_done", done, 1);
      checkOutput("t4_valid", valid_in, 0);
      tick();
      checkOutput("t4_busy_after", busy, 0);
      checkOutput("t4_done_after", done, 0);
      checkOutput("t4_level_kept", level, 2);

      // 5: signed extremes, issued behind the two pairs kept above
      applyStimulus(10'h200, 10'h200);
      applyStimulus(10'h1FF, 10'h200);
      startFrame(16'd4);
      collectFrame("t5", 4, 1'b1, 20);
      checkOutput("t5_level", level, 0);
      tick();

      // 6: reset in the middle of a frame with five pairs buffered
      for (int i = 0; i < 5; i++) begin
         applyStimulus(10'(300 + i), 10'(400 + i));
      end
      checkOutput("t6_level_pre", level, 5);
      startFrame(16'd7);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      checkOutput("t6_level_rst", level, 0);
      checkOutput("t6_valid_rst", valid_in, 0);
      checkOutput("t6_busy_rst", busy, 0);
      checkOutput("t6_ready_rst", in_ready, 1);
      startFrame(16'd1);
      stray_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (valid_in) stray_valid = 1'b1;
      end
      checkOutput("t6_no_stale", {31'b0, stray_valid}, 0);
      checkOutput("t6_busy_wait", busy, 1);
      applyStimulus(10'd7, 10'd8);
      collectFrame("t6", 1, 1'b1, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
